// File: rtl/io_store_rmw_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_store_rmw_sequencer_if : request, IO bus, alignment and completion signals
// Revision: 1.0
// ---------------------------------------------------------------------------
interface io_store_rmw_sequencer_if #(
  parameter int DATABITWIDTH = 16
);
  logic                    StoreReq_Valid;
  logic                    StoreReq_Ready;
  logic [3:0]              MinorOpcodeIn;
  logic [DATABITWIDTH-1:0] DataAddrIn;
  logic [DATABITWIDTH-1:0] DataIn;

  logic                    IORead_Valid;
  logic                    IORead_Ready;
  logic [DATABITWIDTH-1:0] IORead_Addr;
  logic                    IOResp_Valid;
  logic [DATABITWIDTH-1:0] IOResp_Data;
  logic                    IOResp_Err;

  logic [3:0]              Align_MinorOpcode;
  logic [DATABITWIDTH-1:0] Align_Addr;
  logic [DATABITWIDTH-1:0] Align_Data;
  logic [DATABITWIDTH-1:0] Align_ReadData;
  logic [DATABITWIDTH-1:0] Align_Result;

  logic                    IOWrite_Valid;
  logic                    IOWrite_Ready;
  logic [DATABITWIDTH-1:0] IOWrite_Addr;
  logic [DATABITWIDTH-1:0] IOWrite_Data;

  logic                    Done_Valid;
  logic                    Done_Err;

  // Sequencer side: it masters the IO bus and the alignment hand-off.
  modport master (
    input  StoreReq_Valid, MinorOpcodeIn, DataAddrIn, DataIn,
    input  IORead_Ready, IOResp_Valid, IOResp_Data, IOResp_Err,
    input  Align_Result, IOWrite_Ready,
    output StoreReq_Ready, IORead_Valid, IORead_Addr,
    output Align_MinorOpcode, Align_Addr, Align_Data, Align_ReadData,
    output IOWrite_Valid, IOWrite_Addr, IOWrite_Data, Done_Valid, Done_Err
  );

  modport slave (
    output StoreReq_Valid, MinorOpcodeIn, DataAddrIn, DataIn,
    output IORead_Ready, IOResp_Valid, IOResp_Data, IOResp_Err,
    output Align_Result, IOWrite_Ready,
    input  StoreReq_Ready, IORead_Valid, IORead_Addr,
    input  Align_MinorOpcode, Align_Addr, Align_Data, Align_ReadData,
    input  IOWrite_Valid, IOWrite_Addr, IOWrite_Data, Done_Valid, Done_Err
  );
endinterface

`default_nettype wire

// File: rtl/io_store_rmw_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_store_rmw_sequencer : read-modify-write sequencing of sub-word IO stores
// Revision: 1.0
// ---------------------------------------------------------------------------
module io_store_rmw_sequencer #(
  parameter int DATABITWIDTH = 16,
  parameter int READ_TIMEOUT = 255
) (
  input  wire logic                 clk,
  input  wire logic                 async_rst,
  io_store_rmw_sequencer_if.master  bus
);

  localparam int ADDRLSB = $clog2(DATABITWIDTH / 8);
  localparam int CNTW    = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);
  localparam logic [2:0]              NATSZ      = 3'(ADDRLSB);
  localparam logic [DATABITWIDTH-1:0] ALIGN_MASK = ~(DATABITWIDTH'((1 << ADDRLSB) - 1));
  localparam logic [CNTW-1:0]         CNT_LAST   = CNTW'(READ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR_REQ  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state;
  state_t                  next_state;

  logic [3:0]              opcode_reg;
  logic [DATABITWIDTH-1:0] addr_reg;
  logic [DATABITWIDTH-1:0] data_reg;
  logic [DATABITWIDTH-1:0] rdata_reg;
  logic [DATABITWIDTH-1:0] wdata_reg;
  logic [CNTW-1:0]         wait_cnt;
  logic                    err_reg;

  logic                    accept;
  logic                    rd_handshake;
  logic                    wr_handshake;
  logic                    timeout;
  logic                    resp_ok;
  logic                    resp_bad;
  logic [2:0]              req_size;

  assign req_size     = {1'b0, bus.MinorOpcodeIn[1:0]};
  assign accept       = bus.StoreReq_Valid && bus.StoreReq_Ready;
  assign rd_handshake = (state == RD_REQ) && bus.IORead_Ready;
  assign wr_handshake = (state == WR_REQ) && bus.IOWrite_Ready;
  // The cycle in which the counter would reach READ_TIMEOUT is the last wait cycle.
  assign timeout      = (state == RD_WAIT) && (wait_cnt == CNT_LAST);
  assign resp_ok      = (state == RD_WAIT) && bus.IOResp_Valid && !bus.IOResp_Err;
  assign resp_bad     = (state == RD_WAIT) && bus.IOResp_Valid && bus.IOResp_Err;

  // Ready is forced low while reset is held, even though the state reads IDLE.
  assign bus.StoreReq_Ready    = (state == IDLE) && !async_rst;
  assign bus.IORead_Valid      = (state == RD_REQ);
  assign bus.IOWrite_Valid     = (state == WR_REQ);
  assign bus.Done_Valid        = (state == DONE);
  assign bus.Done_Err          = err_reg;

  assign bus.IORead_Addr       = addr_reg & ALIGN_MASK;
  assign bus.IOWrite_Addr      = addr_reg & ALIGN_MASK;
  assign bus.IOWrite_Data      = wdata_reg;

  assign bus.Align_MinorOpcode = opcode_reg;
  assign bus.Align_Addr        = addr_reg;
  assign bus.Align_Data        = data_reg;
  assign bus.Align_ReadData    = rdata_reg;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_size < NATSZ) begin
            next_state = RD_REQ;
          end else if (req_size == NATSZ) begin
            next_state = WR_REQ;
          end else begin
            next_state = DONE;
          end
        end
      end
      RD_REQ: begin
        if (bus.IORead_Ready) begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A response in the timeout cycle takes priority over the abort.
        if (bus.IOResp_Valid) begin
          next_state = bus.IOResp_Err ? DONE : MERGE;
        end else if (timeout) begin
          next_state = DONE;
        end
      end
      MERGE: begin
        next_state = WR_REQ;
      end
      WR_REQ: begin
        if (bus.IOWrite_Ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      opcode_reg <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      rdata_reg  <= '0;
      wdata_reg  <= '0;
      wait_cnt   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        opcode_reg <= bus.MinorOpcodeIn;
        addr_reg   <= bus.DataAddrIn;
        data_reg   <= bus.DataIn;
        wdata_reg  <= bus.DataIn;
        err_reg    <= (req_size > NATSZ);
      end

      if (rd_handshake) begin
        wait_cnt <= '0;
      end else if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (resp_ok) begin
        rdata_reg <= bus.IOResp_Data;
      end

      if (resp_bad || (timeout && !bus.IOResp_Valid)) begin
        err_reg <= 1'b1;
      end

      // Merged word is sampled once; the write phase then holds it stable.
      if (state == MERGE) begin
        wdata_reg <= bus.Align_Result;
      end

      if (wr_handshake) begin
        err_reg <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_store_rmw_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_io_store_rmw_sequencer : directed checks of the store RMW sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_io_store_rmw_sequencer;

  localparam int DW = 16;

  logic clk;
  logic async_rst;
  int   n_cmp;
  int   n_err;
  logic rd_seen;
  logic wr_seen;

  io_store_rmw_sequencer_if #(.DATABITWIDTH(DW)) bif ();

  io_store_rmw_sequencer #(
    .DATABITWIDTH (DW),
    .READ_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian 16-bit alignment stage: byte stores replace one lane.
  always_comb begin
    bif.Align_Result = bif.Align_Data;
    if (bif.Align_MinorOpcode[1:0] == 2'd0) begin
      if (bif.Align_Addr[0]) begin
        bif.Align_Result = {bif.Align_Data[7:0], bif.Align_ReadData[7:0]};
      end else begin
        bif.Align_Result = {bif.Align_ReadData[15:8], bif.Align_Data[7:0]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_seen = rd_seen | bif.IORead_Valid;
    wr_seen = wr_seen | bif.IOWrite_Valid;
  endtask

  // Presents a request for exactly one accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data);
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    bif.StoreReq_Valid = 1'b1;
    bif.MinorOpcodeIn  = op;
    bif.DataAddrIn     = addr;
    bif.DataIn         = data;
    tick();
    bif.StoreReq_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    async_rst = 1'b1;
    bif.StoreReq_Valid = 1'b0;
    bif.MinorOpcodeIn  = '0;
    bif.DataAddrIn     = '0;
    bif.DataIn         = '0;
    bif.IORead_Ready   = 1'b0;
    bif.IOResp_Valid   = 1'b0;
    bif.IOResp_Data    = '0;
    bif.IOResp_Err     = 1'b0;
    bif.IOWrite_Ready  = 1'b0;

    // Reset state
    #3;
    check("rst_ready",  bif.StoreReq_Ready, 0);
    check("rst_rdv",    bif.IORead_Valid, 0);
    check("rst_wrv",    bif.IOWrite_Valid, 0);
    check("rst_done",   bif.Done_Valid, 0);
    check("rst_err",    bif.Done_Err, 0);
    check("rst_rdata",  bif.Align_ReadData, 0);
    tick();
    async_rst = 1'b0;
    #1;
    check("idle_ready", bif.StoreReq_Ready, 1);

    // Stray response in IDLE is ignored
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Data  = 16'hFFFF;
    tick();
    bif.IOResp_Valid = 1'b0;
    check("stray_rdata", bif.Align_ReadData, 0);
    check("stray_ready", bif.StoreReq_Ready, 1);

    // Byte store, zero-latency bus
    issue(4'h0, 16'h0011, 16'h00AB);
    check("b_rdv",    bif.IORead_Valid, 1);
    check("b_rdaddr", bif.IORead_Addr, 16'h0010);
    check("b_ready",  bif.StoreReq_Ready, 0);
    check("b_aop",    bif.Align_MinorOpcode, 4'h0);
    check("b_aaddr",  bif.Align_Addr, 16'h0011);
    check("b_adata",  bif.Align_Data, 16'h00AB);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    check("b_rdv_off", bif.IORead_Valid, 0);
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Data  = 16'h1234;
    tick();
    bif.IOResp_Valid = 1'b0;
    check("b_rdata", bif.Align_ReadData, 16'h1234);
    check("b_wrv_merge", bif.IOWrite_Valid, 0);
    tick();
    check("b_wrv",    bif.IOWrite_Valid, 1);
    check("b_wraddr", bif.IOWrite_Addr, 16'h0010);
    check("b_wrdata", bif.IOWrite_Data, 16'hAB34);
    bif.IOWrite_Ready = 1'b1;
    tick();
    bif.IOWrite_Ready = 1'b0;
    check("b_done",    bif.Done_Valid, 1);
    check("b_doneerr", bif.Done_Err, 0);
    check("b_wrv_off", bif.IOWrite_Valid, 0);
    tick();
    check("b_done_off", bif.Done_Valid, 0);
    check("b_idle",     bif.StoreReq_Ready, 1);

    // Full-width store bypasses the read
    issue(4'h1, 16'h0020, 16'hBEEF);
    check("w_wrv",    bif.IOWrite_Valid, 1);
    check("w_wraddr", bif.IOWrite_Addr, 16'h0020);
    check("w_wrdata", bif.IOWrite_Data, 16'hBEEF);
    bif.IOWrite_Ready = 1'b1;
    tick();
    bif.IOWrite_Ready = 1'b0;
    check("w_done",    bif.Done_Valid, 1);
    check("w_doneerr", bif.Done_Err, 0);
    check("w_noread",  rd_seen, 0);
    tick();

    // Oversized stores: quad and double both exceed the 16-bit bus
    issue(4'h3, 16'h0030, 16'h1111);
    check("q_done",    bif.Done_Valid, 1);
    check("q_doneerr", bif.Done_Err, 1);
    check("q_nobus",   {rd_seen, wr_seen}, 0);
    tick();
    check("q_done_off", bif.Done_Valid, 0);
    issue(4'h2, 16'h0030, 16'h1111);
    check("d_done",    bif.Done_Valid, 1);
    check("d_doneerr", bif.Done_Err, 1);
    tick();

    // Read timeout: Done_Err four cycles after the read handshake
    issue(4'h0, 16'h0011, 16'h00AB);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), bif.Done_Valid, 0);
    end
    tick();
    check("to_done",    bif.Done_Valid, 1);
    check("to_doneerr", bif.Done_Err, 1);
    check("to_nowrite", wr_seen, 0);
    tick();

    // Response in the timeout cycle wins
    issue(4'h0, 16'h0010, 16'h0055);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    tick();
    tick();
    tick();
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Data  = 16'hA0A0;
    tick();
    bif.IOResp_Valid = 1'b0;
    check("tw_nodone", bif.Done_Valid, 0);
    tick();
    check("tw_wrv",    bif.IOWrite_Valid, 1);
    check("tw_wrdata", bif.IOWrite_Data, 16'hA055);
    bif.IOWrite_Ready = 1'b1;
    tick();
    bif.IOWrite_Ready = 1'b0;
    check("tw_doneerr", {bif.Done_Valid, bif.Done_Err}, 2'b10);
    tick();

    // Back-pressure on both bus phases
    issue(4'h0, 16'h0013, 16'h00CD);
    bif.StoreReq_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_rdv%0d", i),   bif.IORead_Valid, 1);
      check($sformatf("bp_rdaddr%0d", i), bif.IORead_Addr, 16'h0012);
      check($sformatf("bp_ready%0d", i), bif.StoreReq_Ready, 0);
      tick();
    end
    bif.StoreReq_Valid = 1'b0;
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Data  = 16'h5678;
    tick();
    bif.IOResp_Valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_wrv%0d", i),    bif.IOWrite_Valid, 1);
      check($sformatf("bp_wraddr%0d", i), bif.IOWrite_Addr, 16'h0012);
      check($sformatf("bp_wrdata%0d", i), bif.IOWrite_Data, 16'hCD78);
      check($sformatf("bp_wready%0d", i), bif.StoreReq_Ready, 0);
      tick();
    end
    bif.IOWrite_Ready = 1'b1;
    tick();
    bif.IOWrite_Ready = 1'b0;
    check("bp_done", {bif.Done_Valid, bif.Done_Err}, 2'b10);
    tick();

    // Asynchronous reset during RD_WAIT
    issue(4'h0, 16'h0031, 16'h00EE);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    #2;
    async_rst = 1'b1;
    #1;
    check("ar_valids", {bif.IORead_Valid, bif.IOWrite_Valid, bif.Done_Valid}, 3'b000);
    check("ar_ready",  bif.StoreReq_Ready, 0);
    check("ar_aaddr",  bif.Align_Addr, 0);
    tick();
    async_rst = 1'b0;
    #1;
    check("ar_nodone", bif.Done_Valid, 0);
    check("ar_idle",   bif.StoreReq_Ready, 1);

    issue(4'h0, 16'h0040, 16'h0077);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Data  = 16'h9ABC;
    tick();
    bif.IOResp_Valid = 1'b0;
    tick();
    check("ar2_wraddr", bif.IOWrite_Addr, 16'h0040);
    check("ar2_wrdata", bif.IOWrite_Data, 16'h9A77);
    bif.IOWrite_Ready = 1'b1;
    tick();
    bif.IOWrite_Ready = 1'b0;
    check("ar2_done", {bif.Done_Valid, bif.Done_Err}, 2'b10);
    tick();

    // Read response error
    issue(4'h0, 16'h0051, 16'h0012);
    bif.IORead_Ready = 1'b1;
    tick();
    bif.IORead_Ready = 1'b0;
    bif.IOResp_Valid = 1'b1;
    bif.IOResp_Err   = 1'b1;
    bif.IOResp_Data  = 16'h4321;
    tick();
    bif.IOResp_Valid = 1'b0;
    bif.IOResp_Err   = 1'b0;
    check("re_done",    {bif.Done_Valid, bif.Done_Err}, 2'b11);
    check("re_nowrite", wr_seen, 0);
    tick();
    check("re_idle", {bif.Done_Valid, bif.StoreReq_Ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
